// File: rtl/dice_turn_controller.sv
// Turn controller for a two-player dice board game.
// A voted die colour sets how many squares the current player advances. The
// token then moves one square every STEP_DELAY clocks. The turn passes to the
// other player once the die is removed. The first token to reach FINISH_POS wins.
module dice_turn_controller #(
  parameter logic [5:0]  FINISH_POS  = 6'd20,
  parameter logic [23:0] STEP_DELAY  = 24'd12_500_000,
  parameter logic [1:0]  STEPS_RED   = 2'd1,
  parameter logic [1:0]  STEPS_GREEN = 2'd2,
  parameter logic [1:0]  STEPS_BLUE  = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] stable_color,
  input  logic       result_ready,
  input  logic       turn_end,
  output logic [2:0] state,
  output logic       cur_player,
  output logic [5:0] p0_pos,
  output logic [5:0] p1_pos,
  output logic [1:0] steps_left,
  output logic       step_pulse,
  output logic       turn_done,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_DICE  = 3'd1,
    S_MOVE       = 3'd2,
    S_WAIT_CLEAR = 3'd3,
    S_GAME_OVER  = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_cur_player;
  logic [5:0]  r_p0_pos;
  logic [5:0]  r_p1_pos;
  logic [1:0]  r_steps_left;
  logic        r_step_pulse;
  logic        r_turn_done;
  logic        r_game_over;
  logic        r_winner;
  logic [23:0] r_timer;
  logic        r_pending;   // die removed while the token was still moving

  logic [1:0]  w_color_steps;
  logic [5:0]  w_cur_pos;
  logic [5:0]  w_next_pos;
  logic [23:0] w_delay_m1;

  assign w_delay_m1 = STEP_DELAY - 24'd1;
  assign w_cur_pos  = r_cur_player ? r_p1_pos : r_p0_pos;
  assign w_next_pos = w_cur_pos + 6'd1;

  // Map the voted die colour to the number of squares to advance
  always_comb begin
    w_color_steps = 2'd0;
    case (stable_color)
      2'b01:   w_color_steps = STEPS_RED;
      2'b10:   w_color_steps = STEPS_GREEN;
      2'b11:   w_color_steps = STEPS_BLUE;
      default: w_color_steps = 2'd0;
    endcase
  end

  // Game FSM with all outputs registered; start overrides every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cur_player <= 1'b0;
      r_p0_pos     <= 6'd0;
      r_p1_pos     <= 6'd0;
      r_steps_left <= 2'd0;
      r_step_pulse <= 1'b0;
      r_turn_done  <= 1'b0;
      r_game_over  <= 1'b0;
      r_winner     <= 1'b0;
      r_timer      <= 24'd0;
      r_pending    <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;
      r_turn_done  <= 1'b0;
      if (start) begin
        r_state      <= S_WAIT_DICE;
        r_cur_player <= 1'b0;
        r_p0_pos     <= 6'd0;
        r_p1_pos     <= 6'd0;
        r_steps_left <= 2'd0;
        r_game_over  <= 1'b0;
        r_winner     <= 1'b0;
        r_timer      <= 24'd0;
        r_pending    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
          end
          S_WAIT_DICE: begin
            if (result_ready && stable_color != 2'b00) begin
              r_steps_left <= w_color_steps;
              r_timer      <= w_delay_m1;
              r_state      <= S_MOVE;
            end
          end
          S_MOVE: begin
            if (turn_end) begin
              r_pending <= 1'b1;
            end
            if (r_timer == 24'd0) begin
              if (r_cur_player) begin
                r_p1_pos <= w_next_pos;
              end else begin
                r_p0_pos <= w_next_pos;
              end
              r_step_pulse <= 1'b1;
              r_timer      <= w_delay_m1;
              if (w_next_pos == FINISH_POS) begin
                // Remaining steps are discarded so the token stops on the finish square
                r_state      <= S_GAME_OVER;
                r_game_over  <= 1'b1;
                r_winner     <= r_cur_player;
                r_steps_left <= 2'd0;
                r_pending    <= 1'b0;
              end else begin
                r_steps_left <= r_steps_left - 2'd1;
                if (r_steps_left == 2'd1) begin
                  r_state <= S_WAIT_CLEAR;
                end
              end
            end else begin
              r_timer <= r_timer - 24'd1;
            end
          end
          S_WAIT_CLEAR: begin
            if (turn_end || r_pending) begin
              r_cur_player <= ~r_cur_player;
              r_pending    <= 1'b0;
              r_turn_done  <= 1'b1;
              r_state      <= S_WAIT_DICE;
            end
          end
          S_GAME_OVER: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign state      = r_state;
  assign cur_player = r_cur_player;
  assign p0_pos     = r_p0_pos;
  assign p1_pos     = r_p1_pos;
  assign steps_left = r_steps_left;
  assign step_pulse = r_step_pulse;
  assign turn_done  = r_turn_done;
  assign game_over  = r_game_over;
  assign winner     = r_winner;

endmodule

// File: tb/tb_dice_turn_controller.sv
// Directed bench for dice_turn_controller with STEP_DELAY=4 and FINISH_POS=5.
module tb_dice_turn_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] stable_color;
  logic       result_ready;
  logic       turn_end;
  logic [2:0] state;
  logic       cur_player;
  logic [5:0] p0_pos;
  logic [5:0] p1_pos;
  logic [1:0] steps_left;
  logic       step_pulse;
  logic       turn_done;
  logic       game_over;
  logic       winner;

  int total = 0;
  int bad   = 0;

  dice_turn_controller #(
    .FINISH_POS (6'd5),
    .STEP_DELAY (24'd4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stable_color (stable_color),
    .result_ready (result_ready),
    .turn_end     (turn_end),
    .state        (state),
    .cur_player   (cur_player),
    .p0_pos       (p0_pos),
    .p1_pos       (p1_pos),
    .steps_left   (steps_left),
    .step_pulse   (step_pulse),
    .turn_done    (turn_done),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  // Packed output snapshot: state, cur_player, p0, p1, steps_left, step_pulse, turn_done, game_over, winner
  function automatic logic [21:0] pack_out(input logic [2:0] st, input logic cp,
                                           input logic [5:0] a, input logic [5:0] b,
                                           input logic [1:0] sl, input logic sp,
                                           input logic td, input logic go, input logic w);
    return {st, cp, a, b, sl, sp, td, go, w};
  endfunction

  typedef struct {
    logic        st;
    logic [1:0]  col;
    logic        rr;
    logic        te;
    logic [21:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic [1:0] c, input logic r, input logic t,
                     input logic [2:0] est, input logic ecp, input logic [5:0] ep0,
                     input logic [5:0] ep1, input logic [1:0] esl, input logic esp,
                     input logic etd, input logic ego, input logic ew);
    vec_t v;
    v.st = s; v.col = c; v.rr = r; v.te = t;
    v.exp_out = pack_out(est, ecp, ep0, ep1, esl, esp, etd, ego, ew);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [21:0] exp_v);
    logic [21:0] act;
    act = pack_out(state, cur_player, p0_pos, p1_pos, steps_left, step_pulse,
                   turn_done, game_over, winner);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got st=%0d cp=%0d p0=%0d p1=%0d sl=%0d sp=%0d td=%0d go=%0d w=%0d want st=%0d cp=%0d p0=%0d p1=%0d sl=%0d sp=%0d td=%0d go=%0d w=%0d",
               name, act[21:19], act[18], act[17:12], act[11:6], act[5:4], act[3], act[2], act[1], act[0],
               exp_v[21:19], exp_v[18], exp_v[17:12], exp_v[11:6], exp_v[5:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
    end else begin
      $display("ok   %s st=%0d cp=%0d p0=%0d p1=%0d sl=%0d", name, act[21:19], act[18], act[17:12], act[11:6], act[5:4]);
    end
  endtask

  task automatic cycle(input logic s, input logic [1:0] c, input logic r, input logic t);
    start = s; stable_color = c; result_ready = r; turn_end = t;
    @(posedge clk);
    #1;
    start = 1'b0; result_ready = 1'b0; turn_end = 1'b0; stable_color = 2'b00;
  endtask

  // Roll a colour, let the token move, then remove the die if the turn is still open
  task automatic do_turn(input logic [1:0] c);
    int n;
    cycle(1'b0, c, 1'b1, 1'b0);
    n = 0;
    while (state == 3'd2 && n < 100) begin
      cycle(1'b0, 2'b00, 1'b0, 1'b0);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL move_timeout got state=%0d want state!=2", state);
    end
    if (state == 3'd3) begin
      cycle(1'b0, 2'b00, 1'b0, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stable_color = 2'b00; result_ready = 1'b0; turn_end = 1'b0;

    // IDLE ignores dice and turn_end
    add(0,2'd0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,2'd3,1,0, 0,0,0,0,0,0,0,0,0);
    add(0,2'd0,0,1, 0,0,0,0,0,0,0,0,0);
    // start, then ignored NONE colour and turn_end in WAIT_DICE
    add(1,2'd0,0,0, 1,0,0,0,0,0,0,0,0);
    add(0,2'd0,1,0, 1,0,0,0,0,0,0,0,0);
    add(0,2'd0,0,1, 1,0,0,0,0,0,0,0,0);
    // player 0 rolls BLUE: steps at entry+4, +8, +12
    add(0,2'd3,1,0, 2,0,0,0,3,0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,2'd0,0,0, 2,0,0,0,3,0,0,0,0);
    add(0,2'd0,0,0, 2,0,1,0,2,1,0,0,0);
    add(0,2'd2,1,0, 2,0,1,0,2,0,0,0,0);
    for (int i = 0; i < 2; i++) add(0,2'd0,0,0, 2,0,1,0,2,0,0,0,0);
    add(0,2'd0,0,0, 2,0,2,0,1,1,0,0,0);
    for (int i = 0; i < 3; i++) add(0,2'd0,0,0, 2,0,2,0,1,0,0,0,0);
    add(0,2'd0,0,0, 3,0,3,0,0,1,0,0,0);
    // WAIT_CLEAR waits for turn_end and ignores dice
    add(0,2'd1,1,0, 3,0,3,0,0,0,0,0,0);
    add(0,2'd0,0,1, 1,1,3,0,0,0,1,0,0);
    // player 1 rolls GREEN
    add(0,2'd2,1,0, 2,1,3,0,2,0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,2'd0,0,0, 2,1,3,0,2,0,0,0,0);
    add(0,2'd0,0,0, 2,1,3,1,1,1,0,0,0);
    for (int i = 0; i < 3; i++) add(0,2'd0,0,0, 2,1,3,1,1,0,0,0,0);
    add(0,2'd0,0,0, 3,1,3,2,0,1,0,0,0);
    add(0,2'd0,0,1, 1,0,3,2,0,0,1,0,0);
    // player 0 at 3 rolls BLUE: 4, then 5 wins with one step discarded
    add(0,2'd3,1,0, 2,0,3,2,3,0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,2'd0,0,0, 2,0,3,2,3,0,0,0,0);
    add(0,2'd0,0,0, 2,0,4,2,2,1,0,0,0);
    for (int i = 0; i < 3; i++) add(0,2'd0,0,0, 2,0,4,2,2,0,0,0,0);
    add(0,2'd0,0,0, 4,0,5,2,0,1,0,1,0);
    add(0,2'd3,1,0, 4,0,5,2,0,0,0,1,0);
    add(0,2'd0,0,1, 4,0,5,2,0,0,0,1,0);
    add(1,2'd0,0,0, 1,0,0,0,0,0,0,0,0);
    // turn_end during MOVE: one WAIT_CLEAR cycle, then turn passes unprompted
    add(0,2'd1,1,0, 2,0,0,0,1,0,0,0,0);
    add(0,2'd0,0,1, 2,0,0,0,1,0,0,0,0);
    for (int i = 0; i < 2; i++) add(0,2'd0,0,0, 2,0,0,0,1,0,0,0,0);
    add(0,2'd0,0,0, 3,0,1,0,0,1,0,0,0);
    add(0,2'd0,0,0, 1,1,1,0,0,0,1,0,0);
    add(0,2'd0,0,0, 1,1,1,0,0,0,0,0,0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", pack_out(3'd0,0,6'd0,6'd0,2'd0,0,0,0,0));
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].st, vecs[i].col, vecs[i].rr, vecs[i].te);
      check($sformatf("vec%0d", i), vecs[i].exp_out);
    end

    // Asynchronous reset in the middle of a move, away from any clock edge
    cycle(1'b0, 2'b11, 1'b1, 1'b0);
    check("mid_move_entry", pack_out(3'd2,1,6'd1,6'd0,2'd3,0,0,0,0));
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", pack_out(3'd0,0,6'd0,6'd0,2'd0,0,0,0,0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    check("restart", pack_out(3'd1,0,6'd0,6'd0,2'd0,0,0,0,0));
    cycle(1'b0, 2'b01, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 2'b00, 1'b0, 1'b0);
    check("fresh_first_step", pack_out(3'd3,0,6'd1,6'd0,2'd0,1,0,0,0));
    cycle(1'b0, 2'b00, 1'b0, 1'b1);
    check("fresh_handover", pack_out(3'd1,1,6'd1,6'd0,2'd0,0,1,0,0));

    // Player 1 wins: p0 1->4, p1 0->3->5
    do_turn(2'b11);
    do_turn(2'b11);
    do_turn(2'b11);
    do_turn(2'b10);
    check("p1_wins", pack_out(3'd4,1,6'd4,6'd5,2'd0,0,0,1,1));
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
    check("p1_wins_hold", pack_out(3'd4,1,6'd4,6'd5,2'd0,0,0,1,1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
